surfboard_matmul_seq: RTL and testbench
=======================================

Name: surfboard_matmul_seq

Overview:
Sequential N×N matrix multiplier for the surfboard arithmetic family. It computes C = A·B over W-bit elements using one time-shared multiply-accumulate unit. Operands arrive on a valid/ready input channel and the result leaves on a valid/ready output channel. It sits between the operand buffers and the result sink, and replaces fixed 2×2 combinational instances where area matters more than latency.

Parameters:
N, 2, matrix dimension (N ≥ 2)
W, 4, element width in bits (W ≥ 2)
SIGNED, 0, 1 = two's-complement operands and result; 0 = unsigned

Ports:
clk  in  1  clock; all state changes on its rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept operands
a_i  in  N*N*W  matrix A, row-major; element (r,c) at bits [(r*N+c)*W +: W]
b_i  in  N*N*W  matrix B, same layout as a_i
out_valid  out  1  c_o holds a complete result
out_ready  in  1  sink accepts result
c_o  out  N*N*W  matrix C, same layout as a_i
busy_o  out  1  high in CALC
ovf_o  out  1  at least one C element saturated in the current result (see Optional Feature)

Behaviour:
- Reset (rst=1 at edge): state IDLE, out_valid=0, c_o=0, busy_o=0, ovf_o=0, all indices and accumulator cleared. Reset wins over every other event. Reset mid-CALC or in DONE discards the in-flight result with no output beat.
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. If in_valid=1, latch a_i/b_i, clear i/j/k/acc/ovf, go to CALC.
- CALC: in_ready=0, busy_o=1. Each cycle acc += A[i][k]*B[k][j].
  - Indices step k fastest, then j, then i.
  - When k=N-1: write C[i][j] = fmt(acc + product), clear acc, k=0, advance j, then i.
  - After the step with i=j=k=N-1, go to DONE.
- DONE: out_valid=1. c_o and ovf_o stay stable while out_ready=0. When out_ready=1, go to IDLE.
- out_valid never drops without a handshake, except on rst.
- in_valid is ignored outside IDLE.
- Latency: handshake at edge e0, then N³ CALC edges, then out_valid=1 after edge e0+N³. Minimum period per operation is N³+2 cycles.
- c_o updates only during CALC. Elements not yet computed keep their previous-result values, and c_o is only valid when out_valid=1.
- Arithmetic:
  - Products are full precision, 2W bits, sign-extended when SIGNED=1.
  - ACC_W = 2W + clog2(N), so the accumulator cannot overflow.
  - Default fmt() takes the low W bits (wrap modulo 2^W). This equals the sum of W-bit-truncated products.

Optional Feature:
- Macro SURFBOARD_MATMUL_SAT_EN.
- Defined: fmt() saturates instead of wrapping.
  - SIGNED=1: clamp to [-2^(W-1), 2^(W-1)-1].
  - SIGNED=0: clamp to [0, 2^W-1].
  - ovf_o is sticky per operation: set when any element clamps, cleared on operand accept.
- Undefined: wrap behaviour as above, and ovf_o is tied to 0.

Decomposition:
- Package surfboard_pkg holds:
  - state enum type (IDLE, CALC, DONE)
  - acc_width(W, N) constant function
  - fmt_wrap and fmt_sat functions, parametrised by signedness
- One sub-module, surfboard_mac: registered ACC_W accumulator with clear, add-product and signed/unsigned select.

Test Plan:
1. N=2, W=4, SIGNED=0, A=[1,2,3,4], B=[5,6,7,8], macro off -> c_o=[3,6,11,2]; out_valid rises exactly 8 cycles after accept; ovf_o=0.
2. Same operands with SURFBOARD_MATMUL_SAT_EN -> c_o=[15,15,15,15], ovf_o=1.
3. N=2, W=4, SIGNED=1, A=B=[-8,0,0,-8] -> wrap: c_o=[0,0,0,0]; sat: c_o=[7,0,0,7], ovf_o=1.
4. N=3, W=8, A=identity, B=[1..9] -> c_o=[1..9], latency 27 cycles, busy_o high for exactly 27 cycles.
5. Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and a_i -> c_o stable, in_ready=0, no second accept. out_ready=1 returns to IDLE next cycle.
6. Assert rst for 1 cycle mid-CALC (cycle 3) -> next cycle IDLE, out_valid=0, c_o=0, in_ready=1. A fresh operand pair then completes normally.

Source files
------------

// File: rtl/surfboard_pkg.sv
// Shared types and arithmetic helpers for the surfboard matrix blocks.
// Formatting helpers work on a 64-bit sign/zero-extended accumulator value.
package surfboard_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int MAXW = 64;
    typedef logic [MAXW-1:0] wide_t;

    function automatic int acc_width(input int w, input int n);
        return 2 * w + $clog2(n);
    endfunction

    function automatic wide_t fmt_wrap(input wide_t v, input int w);
        return v & ((wide_t'(1) << w) - wide_t'(1));
    endfunction

    // Largest representable magnitude; the signed minimum is its bitwise inverse.
    function automatic wide_t sat_max(input int w, input logic sgn);
        return (wide_t'(1) << (sgn ? w - 1 : w)) - wide_t'(1);
    endfunction

    function automatic logic sat_hit(input wide_t v, input int w, input logic sgn);
        wide_t hi;
        hi = sat_max(w, sgn);
        if (sgn)
            return (signed'(v) > signed'(hi)) || (signed'(v) < signed'(~hi));
        return v > hi;
    endfunction

    function automatic wide_t fmt_sat(input wide_t v, input int w, input logic sgn);
        wide_t hi;
        hi = sat_max(w, sgn);
        if (!sat_hit(v, w, sgn))
            return fmt_wrap(v, w);
        if (sgn && v[MAXW-1])
            return fmt_wrap(~hi, w);
        return fmt_wrap(hi, w);
    endfunction

endpackage

// File: rtl/surfboard_mac.sv
// Registered multiply-accumulate: acc <= acc + a*b with synchronous clear.
// 'sum' exposes the not-yet-registered acc + product for the final step of a dot product.
module surfboard_mac #(
    parameter int W      = 4,
    parameter int ACC_W  = 9,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [ACC_W-1:0] sum
);

    logic [2*W-1:0]   a_x, b_x, prod;
    logic [ACC_W-1:0] prod_ext, acc;

    // Extending both operands to 2W first gives the exact product in the low 2W bits.
    assign a_x      = {{W{SIGNED && a[W-1]}}, a};
    assign b_x      = {{W{SIGNED && b[W-1]}}, b};
    assign prod     = a_x * b_x;
    assign prod_ext = {{(ACC_W-2*W){SIGNED && prod[2*W-1]}}, prod};
    assign sum      = acc + prod_ext;

    always_ff @(posedge clk) begin
        if (rst || clr)
            acc <= '0;
        else if (en)
            acc <= sum;
    end

endmodule

// File: rtl/surfboard_matmul_seq.sv
// Sequential NxN matrix multiplier C = A*B on one shared MAC, valid/ready in and out.
// Define SURFBOARD_MATMUL_SAT_EN to saturate result elements and report clamping on ovf_o.
module surfboard_matmul_seq
    import surfboard_pkg::*;
#(
    parameter int N      = 2,
    parameter int W      = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*N*W-1:0] a_i,
    input  logic [N*N*W-1:0] b_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*N*W-1:0] c_o,
    output logic             busy_o,
    output logic             ovf_o
);

    localparam int ACC_W = acc_width(W, N);
    localparam int IW    = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    // Handshakes: a beat moves on a rising edge where valid and ready are both high;
    // out_valid holds with stable c_o/ovf_o until out_ready is seen.
    state_t           state, state_nx;
    logic [IW-1:0]    i, j, k;
    logic [N*N*W-1:0] a_q, b_q, c_q;
    logic [W-1:0]     a_el, b_el, c_el;
    logic [ACC_W-1:0] sum;
    wide_t            sum_x;
    logic             accept, row_end, last_step;

    assign accept    = (state == IDLE) && in_valid;
    assign row_end   = (state == CALC) && (k == LAST);
    assign last_step = row_end && (i == LAST) && (j == LAST);
    assign a_el      = a_q[(int'(i) * N + int'(k)) * W +: W];
    assign b_el      = b_q[(int'(k) * N + int'(j)) * W +: W];
    assign c_o       = c_q;

    surfboard_mac #(.W(W), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (accept || row_end),
        .en  (state == CALC),
        .a   (a_el),
        .b   (b_el),
        .sum (sum)
    );

    always_comb begin
        sum_x            = '0;
        sum_x[ACC_W-1:0] = sum;
        if (SIGNED && sum[ACC_W-1])
            sum_x[MAXW-1:ACC_W] = '1;
    end

`ifdef SURFBOARD_MATMUL_SAT_EN
    logic ovf_q;
    assign c_el  = W'(fmt_sat(sum_x, W, SIGNED));
    assign ovf_o = ovf_q;

    always_ff @(posedge clk) begin
        if (rst || accept)
            ovf_q <= 1'b0;
        else if (row_end && sat_hit(sum_x, W, SIGNED))
            ovf_q <= 1'b1;
    end
`else
    assign c_el  = W'(fmt_wrap(sum_x, W));
    assign ovf_o = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        busy_o    = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = CALC;
            end
            CALC: begin
                busy_o = 1'b1;
                if (last_step) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_q <= a_i;
                b_q <= b_i;
                i   <= '0;
                j   <= '0;
                k   <= '0;
            end else if (state == CALC) begin
                if (k == LAST) begin
                    k <= '0;
                    c_q[(int'(i) * N + int'(j)) * W +: W] <= c_el;
                    if (j == LAST) begin
                        j <= '0;
                        i <= (i == LAST) ? '0 : i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end else begin
                    k <= k + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_surfboard_matmul_seq.sv
// Bench for surfboard_matmul_seq: 2x2 unsigned and signed W=4 instances plus a 3x3 W=8 instance.
// Expected values follow the SURFBOARD_MATMUL_SAT_EN setting of the build.
module tb_surfboard_matmul_seq;

`ifdef SURFBOARD_MATMUL_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        int          d;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic        ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // index 0: unsigned, index 1: signed (both N=2, W=4)
    logic        iv[2], ir[2], ov[2], ordy[2], busy[2], ovf[2];
    logic [15:0] a[2], b[2], c[2];
    // 3x3, W=8 unsigned
    logic        iv3, ir3, ov3, ordy3, busy3, ovf3;
    logic [71:0] a3, b3, c3;

    int          checks = 0;
    int          errors = 0;
    logic [71:0] exp_q[$];
    logic        exp_ovf_q[$];
    vec_t        tbl[$];

    surfboard_matmul_seq #(.N(2), .W(4), .SIGNED(1'b0)) u_dut_u (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a_i(a[0]), .b_i(b[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .c_o(c[0]), .busy_o(busy[0]), .ovf_o(ovf[0])
    );

    surfboard_matmul_seq #(.N(2), .W(4), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a_i(a[1]), .b_i(b[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .c_o(c[1]), .busy_o(busy[1]), .ovf_o(ovf[1])
    );

    surfboard_matmul_seq #(.N(3), .W(8), .SIGNED(1'b0)) u_dut_3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .a_i(a3), .b_i(b3),
        .out_valid(ov3), .out_ready(ordy3), .c_o(c3), .busy_o(busy3), .ovf_o(ovf3)
    );

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plain 2x2 W=4 unsigned product, clamped to 15 when saturation is built in.
    function automatic logic [16:0] model_u(input logic [15:0] av, input logic [15:0] bv);
        logic [15:0] cv;
        logic        o;
        int          s;
        cv = '0;
        o  = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int cc = 0; cc < 2; cc++) begin
                s = 0;
                for (int kk = 0; kk < 2; kk++)
                    s += int'(av[(r*2+kk)*4 +: 4]) * int'(bv[(kk*2+cc)*4 +: 4]);
                if (SAT && s > 15) begin
                    o = 1'b1;
                    s = 15;
                end
                cv[(r*2+cc)*4 +: 4] = 4'(s);
            end
        end
        return {o, cv};
    endfunction

    task automatic wait_out(input int d, output int cyc);
        cyc = 0;
        while (!ov[d] && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic collect(input int d);
        logic [71:0] e;
        logic        eo;
        chk("out_valid_at_collect", 72'(ov[d]), 72'd1);
        if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 72'(exp_q.size()), 72'd1);
        end else begin
            e  = exp_q.pop_front();
            eo = exp_ovf_q.pop_front();
            chk("c_o", 72'(c[d]), e);
            chk("ovf_o", 72'(ovf[d]), 72'(eo));
        end
        ordy[d] = 1'b1;
        tick();
        ordy[d] = 1'b0;
        chk("out_valid_after_hs", 72'(ov[d]), 72'd0);
        chk("in_ready_after_hs", 72'(ir[d]), 72'd1);
    endtask

    task automatic accept_op(input int d, input logic [15:0] av, input logic [15:0] bv,
                             input logic [15:0] ce, input logic oe);
        chk("in_ready_idle", 72'(ir[d]), 72'd1);
        a[d]  = av;
        b[d]  = bv;
        iv[d] = 1'b1;
        tick();
        iv[d] = 1'b0;
        exp_q.push_back(72'(ce));
        exp_ovf_q.push_back(oe);
    endtask

    task automatic op(input int d, input logic [15:0] av, input logic [15:0] bv,
                      input logic [15:0] ce, input logic oe);
        int cyc;
        accept_op(d, av, bv, ce, oe);
        wait_out(d, cyc);
        chk("latency_2x2", 72'(cyc), 72'd8);
        collect(d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          busy_cnt;
        logic [16:0] m;
        logic [15:0] ra, rb;
        logic [71:0] e3;

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b0; a[d] = '0; b[d] = '0;
        end
        iv3 = 1'b0; ordy3 = 1'b0; a3 = '0; b3 = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_out_valid", 72'(ov[0]), 72'd0);
        chk("rst_c_o", 72'(c[0]), 72'd0);
        chk("rst_busy", 72'(busy[0]), 72'd0);
        chk("rst_ovf", 72'(ovf[0]), 72'd0);
        chk("rst_in_ready", 72'(ir[0]), 72'd1);
        chk("rst_c_o_3x3", c3, 72'd0);

        tbl.push_back('{0, 16'h4321, 16'h8765, SAT ? 16'hFFFF : 16'h2B63, SAT});
        tbl.push_back('{0, 16'h1001, 16'hCBA9, 16'hCBA9, 1'b0});
        tbl.push_back('{0, 16'h0000, 16'h0000, 16'h0000, 1'b0});
        tbl.push_back('{0, 16'hFFFF, 16'h1001, 16'hFFFF, 1'b0});
        tbl.push_back('{0, 16'h2002, 16'h8118, SAT ? 16'hF22F : 16'h0220, SAT});
        tbl.push_back('{1, 16'h8008, 16'h8008, SAT ? 16'h7007 : 16'h0000, SAT});
        tbl.push_back('{1, 16'hC32F, 16'h1111, 16'hFF11, 1'b0});
        tbl.push_back('{1, 16'h00F8, 16'h0101, SAT ? 16'h0008 : 16'h0007, SAT});
        for (int n = 0; n < 4; n++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            m  = model_u(ra, rb);
            tbl.push_back('{0, ra, rb, m[15:0], m[16]});
        end
        for (int n = 0; n < tbl.size(); n++)
            op(tbl[n].d, tbl[n].a, tbl[n].b, tbl[n].c, tbl[n].ovf);

        // Backpressure in DONE: result must hold and no new operands may be taken.
        accept_op(0, 16'h4321, 16'h8765, SAT ? 16'hFFFF : 16'h2B63, SAT);
        wait_out(0, cyc);
        chk("latency_bp", 72'(cyc), 72'd8);
        for (int t = 0; t < 10; t++) begin
            iv[0] = t[0];
            a[0]  = 16'($urandom_range(0, 65535));
            tick();
            chk("bp_c_o_stable", 72'(c[0]), exp_q.size() > 0 ? exp_q[0] : 72'hX);
            chk("bp_in_ready", 72'(ir[0]), 72'd0);
            chk("bp_out_valid", 72'(ov[0]), 72'd1);
            chk("bp_ovf_stable", 72'(ovf[0]), 72'(SAT));
        end
        iv[0] = 1'b0;
        collect(0);
        tick();
        chk("bp_no_second_accept", 72'(busy[0]), 72'd0);

        // Reset on the third CALC cycle drops the operation without an output beat.
        chk("mid_rst_in_ready", 72'(ir[0]), 72'd1);
        a[0] = 16'h4321; b[0] = 16'h8765; iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_out_valid", 72'(ov[0]), 72'd0);
        chk("mid_rst_c_o", 72'(c[0]), 72'd0);
        chk("mid_rst_in_ready_after", 72'(ir[0]), 72'd1);
        chk("mid_rst_busy", 72'(busy[0]), 72'd0);
        tick();
        chk("mid_rst_stays_idle", 72'(ov[0]), 72'd0);
        op(0, 16'h1001, 16'hCBA9, 16'hCBA9, 1'b0);

        // 3x3 identity times 1..9
        for (int r = 0; r < 3; r++) begin
            for (int cc = 0; cc < 3; cc++) begin
                a3[(r*3+cc)*8 +: 8] = (r == cc) ? 8'd1 : 8'd0;
                b3[(r*3+cc)*8 +: 8] = 8'(r * 3 + cc + 1);
            end
        end
        e3 = b3;
        exp_q.push_back(e3);
        exp_ovf_q.push_back(1'b0);
        chk("in_ready_3x3", 72'(ir3), 72'd1);
        iv3 = 1'b1;
        tick();
        iv3 = 1'b0;
        cyc = 0;
        busy_cnt = 0;
        while (!ov3 && cyc < 300) begin
            if (busy3) busy_cnt++;
            tick();
            cyc++;
        end
        chk("latency_3x3", 72'(cyc), 72'd27);
        chk("busy_cycles_3x3", 72'(busy_cnt), 72'd27);
        chk("busy_low_in_done_3x3", 72'(busy3), 72'd0);
        if (exp_q.size() > 0) begin
            chk("c_o_3x3", c3, exp_q.pop_front());
            chk("ovf_o_3x3", 72'(ovf3), 72'(exp_ovf_q.pop_front()));
        end else begin
            chk("scoreboard_nonempty_3x3", 72'(exp_q.size()), 72'd1);
        end
        ordy3 = 1'b1;
        tick();
        ordy3 = 1'b0;
        chk("out_valid_after_hs_3x3", 72'(ov3), 72'd0);
        chk("in_ready_after_hs_3x3", 72'(ir3), 72'd1);

        chk("scoreboard_drained", 72'(exp_q.size()), 72'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
